hilo_mul_ctrl: RTL

//  Consumer of the 64-bit multiplier: accepts MULT/MULTU/MTHI/MTLO from the multi-cycle control unit,

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_mul_ctrl_if.sv | 32 +++
 rtl/hilo_mul_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: register width,
// op_code encodings and FSM state type.
package hilo_pkg;

  localparam int unsigned HILO_W = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MADDU = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// Bundle of request, HI/LO export and multiplier signals around hilo_mul_ctrl.
// slave  : the controller itself.
// master : the surrounding control unit plus the multiplier.
interface hilo_mul_ctrl_if;
  import hilo_pkg::*;

  logic                  op_valid;
  logic [2:0]            op_code;
  logic [HILO_W-1:0]     rs_val;
  logic [HILO_W-1:0]     rt_val;
  logic                  op_ready;
  logic                  busy;
  logic                  done;
  logic [HILO_W-1:0]     hi;
  logic [HILO_W-1:0]     lo;
  logic                  mul_start;
  logic                  mul_signed;
  logic [HILO_W-1:0]     mul_a;
  logic [HILO_W-1:0]     mul_b;
  logic [2*HILO_W-1:0]   mul_z;

  modport slave (
    input  op_valid, op_code, rs_val, rt_val, mul_z,
    output op_ready, busy, done, hi, lo, mul_start, mul_signed, mul_a, mul_b
  );

  modport master (
    output op_valid, op_code, rs_val, rt_val, mul_z,
    input  op_ready, busy, done, hi, lo, mul_start, mul_signed, mul_a, mul_b
  );

endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO multiply controller: accepts MULT/MULTU/MTHI/MTLO, drives the external
// multiplier, waits its fixed latency and writes the product into HI/LO.
// Optional feature macro: HILO_MADD_EN enables MADD/MADDU (accumulate into
// HI/LO); when undefined those codes behave as NOP and no 64-bit adder exists.
module hilo_mul_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LAT = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  hilo_mul_ctrl_if.slave   bus
);

  state_e                state;
  state_e                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  is_mul;
  logic                  is_signed_op;
  logic                  last;
  logic [2*HILO_W-1:0]   result;
`ifdef HILO_MADD_EN
  logic                  is_acc;
  logic                  acc;
`endif

  assign accept = bus.op_valid && (state == S_IDLE);
  assign last   = (cnt == CNT_W'(MUL_LAT - 1));

  // Decode which op codes start a multiply and whether it is signed.
  always_comb begin
    is_mul       = 1'b0;
    is_signed_op = 1'b0;
`ifdef HILO_MADD_EN
    is_acc       = 1'b0;
`endif
    case (bus.op_code)
      OP_MULT:  begin is_mul = 1'b1; is_signed_op = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1; end
`ifdef HILO_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_signed_op = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // Value written to {hi,lo} when the multiply completes.
  always_comb begin
`ifdef HILO_MADD_EN
    result = acc ? ({bus.hi, bus.lo} + bus.mul_z) : bus.mul_z;
`else
    result = bus.mul_z;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state-decoded outputs.
  always_comb begin
    bus.op_ready  = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.mul_start = (state == S_ISSUE);
  end

  // Datapath: operand latches, latency counter, HI/LO and done pulse.
  // Operands stay held after completion because the multiplier reads them
  // combinationally for sign correction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      bus.hi         <= '0;
      bus.lo         <= '0;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.mul_signed <= 1'b0;
      bus.done       <= 1'b0;
`ifdef HILO_MADD_EN
      acc            <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              bus.mul_a      <= bus.rs_val;
              bus.mul_b      <= bus.rt_val;
              bus.mul_signed <= is_signed_op;
`ifdef HILO_MADD_EN
              acc            <= is_acc;
`endif
            end else if (bus.op_code == OP_MTHI) begin
              bus.hi <= bus.rs_val;
            end else if (bus.op_code == OP_MTLO) begin
              bus.lo <= bus.rs_val;
            end
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            {bus.hi, bus.lo} <= result;
            bus.done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
